// File: rtl/fir_decim_out.sv
// fir_decim_out: output stage behind the 4-tap moving-sum FIR.
// After reset it throws away the first SKIP valid sums, which are the pipeline
// fill. It scales each later sum to an average (sum/4) and keeps one of every
// DEC sums. Kept averages go into a DEPTH-entry FIFO, and the FIFO feeds a
// valid/ready consumer.
// Build option: define FIR_DECIM_ROUND_EN to round half-up instead of
// truncating. Latency and handshake are the same in both builds.
// The port named 'reset' is an asynchronous, active-low reset.

module fir_decim_out #(
  parameter int W     = 16,
  parameter int DEC   = 4,
  parameter int SKIP  = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [W+1:0]             s_in,
  input  logic                     s_valid,
  output logic [W-1:0]             out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic                     ovf
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int SKW = (SKIP > 1) ? $clog2(SKIP) : 1;
  localparam int PW  = (DEC > 1) ? $clog2(DEC) : 1;

  localparam logic [CW-1:0]  FULL_CNT  = CW'(DEPTH);
  localparam logic [SKW-1:0] SKIP_LAST = SKW'(SKIP - 1);
  localparam logic [PW-1:0]  DEC_LAST  = PW'(DEC - 1);

  typedef enum logic [0:0] {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } state_t;

  state_t         state;
  logic [SKW-1:0] skip_cnt;
  logic [PW-1:0]  phase;

  logic [W-1:0]   avg;
  logic           keep;
  logic           pop;
  logic           full;
  logic           push_ok;

  logic [W-1:0]   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  // Sequencer: count off the fill samples, then track the decimation phase.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= WARMUP;
      skip_cnt <= '0;
      phase    <= '0;
    end else begin
      unique case (state)
        WARMUP: begin
          if (SKIP == 0) begin
            state <= RUN;
          end else if (s_valid) begin
            if (skip_cnt == SKIP_LAST) begin
              state <= RUN;
            end
            skip_cnt <= skip_cnt + 1'b1;
          end
        end
        RUN: begin
          if (s_valid) begin
            phase <= (phase == DEC_LAST) ? '0 : phase + 1'b1;
          end
        end
        default: state <= WARMUP;
      endcase
    end
  end

  // A sum is kept when it arrives in RUN at decimation phase 0.
  assign keep = (state == RUN) && s_valid && (phase == '0);

`ifdef FIR_DECIM_ROUND_EN
  logic [W+2:0] rsum;
  // Never read: the top bit of the rounded sum. A sum from the FIR is at most
  // 4*(2^W-1), so the rounded average still fits in W bits.
  logic         unused_rsum_msb;

  // Round half-up. The add is one bit wider than the input, so the +2 cannot wrap.
  // NOTE: every signal an always_comb writes gets a default first, so no latch is inferred.
  always_comb begin
    rsum = '0;
    rsum = {1'b0, s_in} + (W + 3)'(2);
    avg  = rsum[W+1:2];
  end

  assign unused_rsum_msb = rsum[W+2];
`else
  // Never read: the two fraction bits that truncation drops.
  logic unused_lsbs;

  // Truncate: sum/4 rounded down. A sum from the FIR fits the W-bit average.
  always_comb begin
    avg = s_in[W+1:2];
  end

  assign unused_lsbs = ^s_in[1:0];
`endif

  // Handshake and FIFO status. A push into a full FIFO still succeeds when a
  // pop frees a slot on the same edge.
  assign out_valid = (fifo_cnt != '0);
  assign pop       = out_valid && out_ready;
  assign full      = (fifo_cnt == FULL_CNT);
  assign push_ok   = keep && (!full || pop);

  // The head entry drives the output. Forcing zero while empty hides whatever
  // the storage holds.
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // FIFO storage. The occupancy count marks which entries are valid.
  // NOTE: the storage array has no reset; only the pointers and count clear.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= avg;
    end
  end

  // Pointers, occupancy count and the sticky overflow flag. Pointers wrap for
  // free because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (keep && full && !pop) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: doc/fir_decim_out.md
Name: fir_decim_out

Overview:
- Output stage that sits directly downstream of the 4-tap moving-sum FIR and consumes its registered sum every cycle.
- Discards the pipeline fill samples after reset, then scales the sum to an average (sum/4).
- Decimates by DEC and buffers the results in a small FIFO.
- Presents the results to the next consumer over a valid/ready handshake.

Parameters:
- W, 16, input sample width of the FIR; the sum input is W+2 bits and the average output is W bits.
- DEC, 4, decimation ratio (>=1); one out of every DEC post-warm-up valid sums is kept.
- SKIP, 4, number of valid input sums discarded after reset (FIR fill).
- DEPTH, 4, FIFO entries; power of 2, >=2.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- s_in  in  W+2  moving sum from the FIR
- s_valid  in  1  s_in is a new sample this cycle
- out_data  out  W  averaged, decimated sample
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts out_data this cycle
- fifo_cnt  out  $clog2(DEPTH)+1  current FIFO occupancy
- ovf  out  1  sticky flag: a kept sample was dropped because the FIFO was full

Behaviour:
- Reset (reset=0, asynchronous):
  - All state clears: out_valid=0, out_data=0, fifo_cnt=0, ovf=0.
  - FSM goes to WARMUP; skip counter=0; decimation phase=0; FIFO pointers=0.
- FSM state WARMUP:
  - Each cycle with s_valid=1 increments the skip counter; nothing is pushed.
  - When the SKIP-th valid sample is consumed, go to RUN.
  - SKIP=0 means the FSM enters RUN on the first clock after reset.
- FSM state RUN:
  - Each s_valid=1 advances the phase counter 0..DEC-1, wrapping to 0.
  - The sample that arrives at phase 0 is kept; the other phases are discarded.
  - RUN has no exit except reset.
- Scaling:
  - avg = s_in[W+1:2], the truncated sum/4, computed at W+2 bits.
  - Result is always <= 2^W-1, so no saturation is needed.
- Push:
  - A kept sample is written to the FIFO on the same clock edge.
  - out_valid rises at the earliest 1 cycle after s_valid, with no combinational bypass.
- Pop:
  - Occurs when out_valid && out_ready.
  - out_data/out_valid are driven from the FIFO head.
  - out_data holds steady while out_valid=1 && out_ready=0.
- Full:
  - A push with fifo_cnt==DEPTH and no simultaneous pop: the sample is dropped, FIFO unchanged, ovf set to 1.
  - ovf stays at 1 until reset.
  - A push and a pop in the same cycle while full: both succeed and fifo_cnt is unchanged.
- Empty:
  - out_valid=0; out_ready is ignored.
  - A push while empty makes out_valid=1 on the next cycle.
- Pointers wrap modulo DEPTH; fifo_cnt ranges 0..DEPTH.
- s_valid=0 cycles leave the skip counter and phase counter unchanged.
- Reset asserted mid-stream flushes the FIFO and restarts WARMUP; partial decimation phase is lost.

Optional Feature:
- Macro: FIR_DECIM_ROUND_EN.
- Defined: avg = (s_in + 2) >> 2, round-half-up; the addition is done at W+3 bits.
  - Maximum result is still 2^W-1; no clipping is needed.
- Undefined: truncation as described in Behaviour.
- Latency and handshake are identical in both builds.

Test Plan:
- Warm-up skip: reset, then s_valid=1 with s_in=100,200,300,400,800 (DEC=1, out_ready=1).
  - Required: the first four samples produce no output.
  - Required: out_data=200 appears 1 cycle after the fifth sample.
- Decimation: in RUN with DEC=4, feed valid sums 40,44,48,52,56,60,64,68.
  - Outputs are 10 then 14 only (truncation build).
  - With FIR_DECIM_ROUND_EN, sum 42 gives 11; without it, 42 gives 10.
- Backpressure and overflow: DEC=1, DEPTH=4, out_ready=0, push 6 kept samples 4,8,12,16,20,24.
  - fifo_cnt=4, ovf=1.
  - Then out_ready=1 yields 1,2,3,4 in order, fifo_cnt drains to 0, ovf stays 1.
- Full with simultaneous push/pop: FIFO full and out_ready=1 while a kept sample arrives.
  - fifo_cnt stays 4, ovf stays 0, and the new sample appears after the 4 older ones.
- Asynchronous reset mid-stream: with fifo_cnt=3, pull reset low between clock edges.
  - out_valid=0, fifo_cnt=0, ovf=0 immediately, without waiting for a clock edge.
  - After release, the next 4 valid sums are discarded again (WARMUP).
- Idle gaps: s_valid toggles 1,0,0,1 with DEC=2 in RUN.
  - Only valid cycles advance the phase.
  - Exactly one output for the two valid samples.
